// File: rtl/tm1638_frame_sequencer.sv
// tm1638_frame_sequencer: serial refresh sequencer for a TM1638 8-digit LED board.
// It snapshots the eight segment bytes, the LEDs, the brightness and the
// display-on flag, then sends three frames:
//   - data command 0x40
//   - 0xC0 followed by 16 display bytes
//   - display control
// Bits go out LSB first on o_clko/o_stb/o_dio. All pins come straight from
// flops, so they cannot glitch.
// Ports:
//   i_clki     system clock (rising edge)
//   i_rst      synchronous active-high reset
//   i_start    refresh request, taken only while not busy
//   i_seg_data byte i = segment pattern of digit i (bit0=a .. bit6=g, bit7=dp)
//   i_leds     bit i = LED i
//   i_bright   brightness 0-7
//   i_disp_on  1 = display on
//   o_clko     TM1638 CLK, idle high
//   o_stb      TM1638 STB, active low
//   o_dio      TM1638 DIO, idle high
//   o_busy     sequence in progress
//   o_done     one-cycle pulse at sequence end
module tm1638_frame_sequencer #(
   parameter int CLK_DIV = 4
) (
   input  logic        i_clki,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [63:0] i_seg_data,
   input  logic [7:0]  i_leds,
   input  logic [2:0]  i_bright,
   input  logic        i_disp_on,
   output logic        o_clko,
   output logic        o_stb,
   output logic        o_dio,
   output logic        o_busy,
   output logic        o_done
);
   localparam int DW = $clog2(CLK_DIV);
   typedef enum logic [2:0] {S_IDLE, S_LEAD, S_BIT, S_TRAIL, S_GAP, S_DONE} state_t;
   state_t r_state, w_state;
   logic [DW-1:0] r_div, w_div;
   logic r_half, w_half;
   logic [2:0] r_bit, w_bit;
   logic [4:0] r_byte, w_byte;
   logic [1:0] r_frame, w_frame;
   logic [63:0] r_seg;
   logic [7:0] r_leds;
   logic [2:0] r_bright;
   logic r_disp_on;
   logic r_clko, r_stb, r_dio, r_busy, r_done;
   logic w_clko, w_stb, w_dio, w_busy, w_done;
   logic w_accept, w_div_end, w_last;
   logic [3:0] w_addr;
   logic [7:0] w_tx;
   assign o_clko = r_clko;
   assign o_stb = r_stb;
   assign o_dio = r_dio;
   assign o_busy = r_busy;
   assign o_done = r_done;
   always_comb begin
      // DONE also accepts, so a held start restarts on the cycle after done
      w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);
      w_div_end = r_div == DW'(CLK_DIV - 1);
      w_last = r_byte == (r_frame == 2'd1 ? 5'd16 : 5'd0);
      w_div = (r_state == S_IDLE || r_state == S_DONE || w_div_end) ? '0 : r_div + 1'b1;
      w_state = r_state;
      w_half = r_half;
      w_bit = r_bit;
      w_byte = r_byte;
      w_frame = r_frame;
      case (r_state)
         S_IDLE, S_DONE: w_state = w_accept ? S_LEAD : S_IDLE;
         S_LEAD: w_state = w_div_end ? S_BIT : S_LEAD;
         S_BIT: begin
            // half 0 = clko low, half 1 = clko high; advance the bit after half 1
            if (w_div_end) begin
               w_half = ~r_half;
               if (r_half) begin
                  w_bit = r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
                     w_byte = w_last ? 5'd0 : r_byte + 5'd1;
                     w_state = w_last ? S_TRAIL : S_BIT;
                  end
               end
            end
         end
         S_TRAIL: w_state = w_div_end ? S_GAP : S_TRAIL;
         S_GAP: begin
            // the gap is two half-cells long
            if (w_div_end) begin
               w_half = ~r_half;
               if (r_half) begin
                  w_state = r_frame == 2'd2 ? S_DONE : S_LEAD;
                  w_frame = r_frame == 2'd2 ? 2'd0 : r_frame + 2'd1;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase
      // the byte on the wire is chosen from the next-state indices, because pins are registered
      w_addr = 4'(w_byte - 5'd1);
      w_tx = w_frame == 2'd0 ? 8'h40 :
             w_frame == 2'd2 ? (r_disp_on ? {5'b10001, r_bright} : 8'h80) :
             w_byte == 5'd0 ? 8'hC0 :
             w_addr[0] ? {7'b0, r_leds[w_addr[3:1]]} : r_seg[{w_addr[3:1], 3'b000} +: 8];
      w_clko = !(w_state == S_BIT && !w_half);
      w_stb = w_state == S_IDLE || w_state == S_GAP || w_state == S_DONE;
      w_dio = w_state != S_BIT || w_tx[w_bit];
      w_busy = !(w_state == S_IDLE || w_state == S_DONE);
      w_done = w_state == S_DONE;
   end
   always_ff @(posedge i_clki) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_div <= '0;
         r_half <= 1'b0;
         r_bit <= 3'd0;
         r_byte <= 5'd0;
         r_frame <= 2'd0;
         r_clko <= 1'b1;
         r_stb <= 1'b1;
         r_dio <= 1'b1;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_state <= w_state;
         r_div <= w_div;
         r_half <= w_half;
         r_bit <= w_bit;
         r_byte <= w_byte;
         r_frame <= w_frame;
         r_clko <= w_clko;
         r_stb <= w_stb;
         r_dio <= w_dio;
         r_busy <= w_busy;
         r_done <= w_done;
      end
   end
   always_ff @(posedge i_clki) begin
      if (!i_rst && w_accept) begin
         r_seg <= i_seg_data;
         r_leds <= i_leds;
         r_bright <= i_bright;
         r_disp_on <= i_disp_on;
      end
   end
endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// tb_tm1638_frame_sequencer: self-checking bench; two instances (CLK_DIV 4 and 2) with pin decoders and a byte scoreboard
module tb_tm1638_frame_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] start = 2'b00;
   logic [63:0] seg = '0;
   logic [7:0] leds = '0;
   logic [2:0] bright = '0;
   logic disp_on = 1'b0;
   logic [1:0] clko, stb, dio, busy, done;
   int n_pass = 0, n_tot = 0, cyc = 0, n0 = 0;
   logic [7:0] exp_q0 [$];
   logic [7:0] exp_q1 [$];
   typedef struct {
      logic [63:0] seg;
      logic [7:0]  leds;
      logic [2:0]  bright;
      logic        on;
      logic [7:0]  ctrl;
   } vec_t;
   vec_t tbl [4];
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input logic ok, input string name, input longint act, input longint req);
      n_tot++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask
   function automatic int qs(input int g);
      return g == 0 ? exp_q0.size() : exp_q1.size();
   endfunction
   function automatic logic [7:0] qpop(input int g);
      return g == 0 ? exp_q0.pop_front() : exp_q1.pop_front();
   endfunction
   task automatic push_exp(input int g, input logic [63:0] s, input logic [7:0] l, input logic [7:0] ctrl);
      logic [7:0] b [$];
      b.push_back(8'h40);
      b.push_back(8'hC0);
      for (int i = 0; i < 8; i++) begin
         b.push_back(s[8*i +: 8]);
         b.push_back({7'b0, l[i]});
      end
      b.push_back(ctrl);
      foreach (b[i]) begin
         if (g == 0) exp_q0.push_back(b[i]);
         else exp_q1.push_back(b[i]);
      end
   endtask
   task automatic pulse(input int g);
      @(posedge clk);
      #1 start[g] = 1'b1;
      @(posedge clk);
      #1 start[g] = 1'b0;
   endtask
   task automatic wait_done(input int g, input int budget);
      logic seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = done[g];
      end
      chk(seen, "done_wait", seen, 1);
   endtask
   task automatic set_in(input int i);
      seg = tbl[i].seg;
      leds = tbl[i].leds;
      bright = tbl[i].bright;
      disp_on = tbl[i].on;
   endtask
   for (genvar g = 0; g < 2; g++) begin : mon
      localparam int D = g == 0 ? 4 : 2;
      logic p_clko = 1'b1, p_stb = 1'b1, p_dio = 1'b1, p_done = 1'b0, p_rst = 1'b1;
      logic in_frame = 1'b0, seq = 1'b0;
      logic [7:0] sh = '0, e = '0;
      int fb = 0, run = 0, srun = 0, frames = 0, t0 = 0, nd = 0;
      tm1638_frame_sequencer #(.CLK_DIV(D)) dut (
         .i_clki(clk), .i_rst(rst), .i_start(start[g]), .i_seg_data(seg),
         .i_leds(leds), .i_bright(bright), .i_disp_on(disp_on),
         .o_clko(clko[g]), .o_stb(stb[g]), .o_dio(dio[g]), .o_busy(busy[g]), .o_done(done[g])
      );
      always @(negedge clk) begin
         if (!p_rst) begin
            if (clko[g] != p_clko) begin
               if (!p_clko) chk(run == D, "clko_low", run, D);
               else if (fb > 0) chk(run == D, "clko_high", run, D);
               else if (in_frame) chk(srun == D, "lead", srun, D);
               if (!p_clko) begin
                  sh = {dio[g], sh[7:1]};
                  fb++;
                  if (fb % 8 == 0) begin
                     chk(qs(g) != 0, "byte_avail", qs(g), 1);
                     if (qs(g) != 0) begin
                        e = qpop(g);
                        chk(sh == e, "byte", sh, e);
                     end
                  end
               end
            end
            if (dio[g] != p_dio) chk(p_clko, "dio_edge", p_clko, 1);
            if (stb[g] != p_stb) begin
               chk(clko[g] && p_clko, "stb_clko", {p_clko, clko[g]}, 2'b11);
               if (stb[g]) begin
                  chk(fb > 0 && fb % 8 == 0, "frame_bits", fb, 8);
                  chk(run == 2 * D, "trail", run, 2 * D);
                  frames++;
                  fb = 0;
                  in_frame = 1'b0;
               end else begin
                  if (seq) chk(srun == 2 * D, "gap", srun, 2 * D);
                  else begin
                     seq = 1'b1;
                     t0 = cyc;
                     frames = 0;
                  end
                  in_frame = 1'b1;
               end
            end
            if (done[g]) begin
               chk(!p_done && !busy[g], "done_pulse", {p_done, busy[g]}, 0);
               chk(seq && cyc - t0 == 316 * D, "total", cyc - t0, 316 * D);
               chk(frames == 3, "frames", frames, 3);
               seq = 1'b0;
               nd++;
            end
         end
         run = clko[g] != p_clko ? 1 : run + 1;
         srun = stb[g] != p_stb ? 1 : srun + 1;
         p_clko = clko[g];
         p_stb = stb[g];
         p_dio = dio[g];
         p_done = done[g];
         if (rst) begin
            in_frame = 1'b0;
            seq = 1'b0;
            fb = 0;
         end
         p_rst = rst;
      end
   end
   initial begin
      tbl[0] = '{64'h0706_0504_0302_013F, 8'hA5, 3'd3, 1'b1, 8'h8B};
      tbl[1] = '{64'h1122_3344_5566_7788, 8'h3C, 3'd7, 1'b0, 8'h80};
      tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'd7, 1'b1, 8'h8F};
      tbl[3] = '{64'h0, 8'h00, 3'd0, 1'b1, 8'h88};
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         chk({clko[k], stb[k], dio[k], busy[k], done[k]} == 5'b11100, "reset_state",
             {clko[k], stb[k], dio[k], busy[k], done[k]}, 5'b11100);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_in(i);
         push_exp(0, tbl[i].seg, tbl[i].leds, tbl[i].ctrl);
         pulse(0);
         wait_done(0, 1500);
         repeat (3) @(negedge clk);
         chk(qs(0) == 0, "bytes_left", qs(0), 0);
         chk(!busy[0], "idle_busy", busy[0], 0);
      end
      set_in(0);
      push_exp(0, tbl[0].seg, tbl[0].leds, 8'h8B);
      pulse(0);
      repeat (200) @(posedge clk);
      #1;
      seg = '1;
      leds = 8'hFF;
      bright = 3'd0;
      disp_on = 1'b0;
      wait_done(0, 1500);
      repeat (3) @(negedge clk);
      chk(qs(0) == 0, "latch_bytes_left", qs(0), 0);
      set_in(0);
      n0 = mon[0].nd;
      push_exp(0, tbl[0].seg, tbl[0].leds, 8'h8B);
      pulse(0);
      repeat (20) @(posedge clk);
      pulse(0);
      wait_done(0, 1500);
      repeat (1400) @(negedge clk);
      chk(mon[0].nd - n0 == 1, "single_done", mon[0].nd - n0, 1);
      chk(qs(0) == 0, "guard_bytes_left", qs(0), 0);
      push_exp(0, tbl[0].seg, tbl[0].leds, 8'h8B);
      push_exp(0, tbl[0].seg, tbl[0].leds, 8'h8B);
      @(posedge clk);
      #1 start[0] = 1'b1;
      wait_done(0, 1500);
      @(posedge clk);
      #1 start[0] = 1'b0;
      @(negedge clk);
      chk(!stb[0] && busy[0], "restart", {stb[0], busy[0]}, 2'b01);
      wait_done(0, 1500);
      repeat (3) @(negedge clk);
      chk(qs(0) == 0, "b2b_bytes_left", qs(0), 0);
      n0 = mon[0].nd;
      push_exp(0, tbl[0].seg, tbl[0].leds, 8'h8B);
      pulse(0);
      repeat (299) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk({clko[0], stb[0], dio[0], busy[0], done[0]} == 5'b11100, "mid_reset",
          {clko[0], stb[0], dio[0], busy[0], done[0]}, 5'b11100);
      rst = 1'b0;
      exp_q0.delete();
      repeat (1500) @(negedge clk);
      chk(mon[0].nd == n0, "no_done_after_reset", mon[0].nd - n0, 0);
      set_in(0);
      push_exp(1, tbl[0].seg, tbl[0].leds, 8'h8B);
      pulse(1);
      wait_done(1, 800);
      repeat (3) @(negedge clk);
      chk(qs(1) == 0, "div2_bytes_left", qs(1), 0);
      chk(mon[1].nd == 1, "div2_done_count", mon[1].nd, 1);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
